// File: rtl/mm_req_arb.sv
`timescale 1ns/1ps
// mm_req_arb
//   Two-requester round-robin front end for a shared Montgomery multiplier core.
//   The winner's job streams N operand beats (x, y) into the core. The core's
//   N result beats are then returned to that requester only.
//
// Ports
//   clk, rst_n          clock; asynchronous reset, active high
//   req[1:0]            per-requester request, held until granted
//   req_type[3:0]       2-bit modulus select per requester
//   req_x/req_y[2K-1:0] per-requester operand words; requester i uses slice i
//   req_valid[1:0]      per-requester operand-beat valid
//   gnt[1:0]            one-hot single-cycle grant pulse
//   busy                FSM not in IDLE
//   res_data[K-1:0]     result word, broadcast to both requesters
//   res_valid[1:0]      result-beat valid, owning requester only
//   res_last            marks the final result beat
//   mm_type/mm_start/mm_x/mm_x_valid/mm_y/mm_y_valid   drive the core
//   mm_result/mm_valid  result stream from the core
module mm_req_arb #(
   parameter int unsigned K = 128,
   parameter int unsigned N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [1:0]     req,
   input  logic [3:0]     req_type,
   input  logic [2*K-1:0] req_x,
   input  logic [2*K-1:0] req_y,
   input  logic [1:0]     req_valid,
   output logic [1:0]     gnt,
   output logic           busy,
   output logic [K-1:0]   res_data,
   output logic [1:0]     res_valid,
   output logic           res_last,
   output logic [1:0]     mm_type,
   output logic           mm_start,
   output logic [K-1:0]   mm_x,
   output logic           mm_x_valid,
   output logic [K-1:0]   mm_y,
   output logic           mm_y_valid,
   input  logic [K-1:0]   mm_result,
   input  logic           mm_valid
);

   localparam int unsigned   CW        = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]    state;
   logic          owner;
   logic          prio;      // requester currently holding highest priority
   logic          win;
   logic          take;
   logic [CW-1:0] in_cnt;
   logic [CW-1:0] out_cnt;

   // Winner: the priority holder if it requests, otherwise the other one.
   always_comb begin
      win = prio;
      if (!req[prio]) win = ~prio;
   end

   // A result beat is consumed on the first mm_valid in WAIT and then on every
   // DRAIN cycle, irrespective of mm_valid.
   assign take = ((state == S_WAIT) && mm_valid) || (state == S_DRAIN);
   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= S_IDLE;
         owner      <= 1'b0;
         prio       <= 1'b0;
         in_cnt     <= '0;
         out_cnt    <= '0;
         gnt        <= '0;
         mm_start   <= 1'b0;
         mm_type    <= '0;
         mm_x       <= '0;
         mm_y       <= '0;
         mm_x_valid <= 1'b0;
         mm_y_valid <= 1'b0;
         res_data   <= '0;
         res_valid  <= '0;
         res_last   <= 1'b0;
      end else begin
         gnt        <= '0;
         mm_start   <= 1'b0;
         mm_x_valid <= 1'b0;
         mm_y_valid <= 1'b0;
         res_valid  <= '0;
         res_last   <= 1'b0;

         case (state)
            S_IDLE: begin
               in_cnt  <= '0;
               out_cnt <= '0;
               if (|req) begin
                  gnt      <= win ? 2'b10 : 2'b01;
                  mm_start <= 1'b1;
                  mm_type  <= win ? req_type[3:2] : req_type[1:0];
                  owner    <= win;
                  prio     <= ~win;
                  state    <= S_LOAD;
               end
            end

            S_LOAD: begin
               if (req_valid[owner]) begin
                  mm_x       <= owner ? req_x[2*K-1:K] : req_x[K-1:0];
                  mm_y       <= owner ? req_y[2*K-1:K] : req_y[K-1:0];
                  mm_x_valid <= 1'b1;
                  mm_y_valid <= 1'b1;
                  in_cnt     <= in_cnt + CW'(1);
                  if (in_cnt == LAST_BEAT) state <= S_WAIT;
               end
            end

            default: ;
         endcase

         if (take) begin
            res_data  <= mm_result;
            res_valid <= owner ? 2'b10 : 2'b01;
            if (out_cnt == LAST_BEAT) begin
               res_last <= 1'b1;
               state    <= S_IDLE;
               in_cnt   <= '0;
               out_cnt  <= '0;
            end else begin
               out_cnt <= out_cnt + CW'(1);
               state   <= S_DRAIN;
            end
         end
      end
   end

endmodule

// File: tb/tb_mm_req_arb.sv
`timescale 1ns/1ps
// tb_mm_req_arb
//   Self-checking bench for mm_req_arb. The bench plays both requesters and a
//   stand-in for the Montgomery core. Expected operand beats and result beats
//   are queued as stimulus is driven; a negedge monitor pops and compares them.
module tb_mm_req_arb;

   localparam int unsigned K = 128;
   localparam int unsigned N = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req;
   logic [3:0]     req_type;
   logic [2*K-1:0] req_x;
   logic [2*K-1:0] req_y;
   logic [1:0]     req_valid;
   logic [1:0]     gnt;
   logic           busy;
   logic [K-1:0]   res_data;
   logic [1:0]     res_valid;
   logic           res_last;
   logic [1:0]     mm_type;
   logic           mm_start;
   logic [K-1:0]   mm_x;
   logic           mm_x_valid;
   logic [K-1:0]   mm_y;
   logic           mm_y_valid;
   logic [K-1:0]   mm_result;
   logic           mm_valid;

   int vectors    = 0;
   int miscompares = 0;
   int fwd_cnt    = 0;
   int cyc        = 0;
   int last_cyc   = -100;
   int gnt_cyc    = -100;

   logic [2*K-1:0] exp_xy[$];
   logic [K+2:0]   exp_res[$];   // {res_valid, res_last, res_data}
   logic [2*K-1:0] e_xy;
   logic [K+2:0]   e_res;

   mm_req_arb #(.K(K), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_type(req_type),
      .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
      .gnt(gnt), .busy(busy), .res_data(res_data), .res_valid(res_valid),
      .res_last(res_last), .mm_type(mm_type), .mm_start(mm_start),
      .mm_x(mm_x), .mm_x_valid(mm_x_valid), .mm_y(mm_y), .mm_y_valid(mm_y_valid),
      .mm_result(mm_result), .mm_valid(mm_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         if (mm_x_valid || mm_y_valid) begin
            vectors++;
            if (mm_x_valid !== mm_y_valid) begin
               miscompares++;
               $display("FAIL xy_valid_pair got %b%b want equal", mm_x_valid, mm_y_valid);
            end
         end
         if (mm_x_valid) begin
            fwd_cnt++;
            vectors++;
            if (exp_xy.size() == 0) begin
               miscompares++;
               $display("FAIL fwd_unexpected got x=%h want no beat", mm_x);
            end else begin
               e_xy = exp_xy.pop_front();
               if ({mm_x, mm_y} !== e_xy) begin
                  miscompares++;
                  $display("FAIL fwd_data got %h want %h", {mm_x, mm_y}, e_xy);
               end
            end
         end
         if ((|res_valid) || res_last) begin
            vectors++;
            if (exp_res.size() == 0) begin
               miscompares++;
               $display("FAIL res_unexpected got v=%b l=%b want none", res_valid, res_last);
            end else begin
               e_res = exp_res.pop_front();
               if ({res_valid, res_last, res_data} !== e_res) begin
                  miscompares++;
                  $display("FAIL res_beat got %h want %h", {res_valid, res_last, res_data}, e_res);
               end
            end
         end
         if (res_last) begin
            last_cyc = cyc;
            vectors++;
            if (busy !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_at_last got %b want 0", busy);
            end
         end
         if (|gnt) gnt_cyc = cyc;
      end
   end

   // ---------------- helpers (stimulus only) ----------------
   function automatic logic [K-1:0] rnd_word();
      logic [K-1:0] w;
      for (int i = 0; i < K / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   task automatic wait_gnt(output logic [1:0] g, output logic st, output logic [1:0] ty,
                           output bit tout);
      bit done = 0;
      int n = 0;
      g = '0; st = 1'b0; ty = '0; tout = 1'b1;
      while (!done && n < 80) begin
         @(negedge clk);
         n++;
         if (|gnt) begin
            g = gnt; st = mm_start; ty = mm_type; tout = 1'b0; done = 1;
         end
      end
      #1;
   endtask

   // Owner streams nbeats valid beats; beats past N are not expected downstream.
   task automatic feed(input int who, input int nbeats, input bit gapped,
                       input bit noise, input bit early_mm);
      int beat = 0;
      int c = 0;
      while (beat < nbeats) begin
         req_x = {rnd_word(), rnd_word()};
         req_y = {rnd_word(), rnd_word()};
         req_valid = '0;
         if (noise) req_valid[1-who] = 1'b1;
         if (!gapped || (c % 2 == 0)) begin
            req_valid[who] = 1'b1;
            if (beat < N) exp_xy.push_back({req_x[who*K +: K], req_y[who*K +: K]});
            beat++;
         end
         if (early_mm && c == 5) begin
            mm_valid = 1'b1; mm_result = rnd_word();
         end else begin
            mm_valid = 1'b0;
         end
         @(negedge clk);
         c++;
      end
      req_valid = '0;
      mm_valid  = 1'b0;
   endtask

   // Core stand-in: beat 0 with mm_valid=1, later beats with random mm_valid.
   task automatic drain(input int who, input int nbeats);
      logic [1:0] oh;
      oh = (who == 1) ? 2'b10 : 2'b01;
      repeat (2) @(negedge clk);
      for (int i = 0; i < nbeats; i++) begin
         mm_result = rnd_word();
         mm_valid  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         exp_res.push_back({oh, (i == N - 1) ? 1'b1 : 1'b0, mm_result});
         @(negedge clk);
      end
      mm_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b1;
      req = '0; req_valid = '0; mm_valid = 1'b0;
      exp_xy.delete(); exp_res.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b1;
      req = '0; req_type = '0; req_x = '0; req_y = '0; req_valid = '0;
      mm_result = '0; mm_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({gnt, busy, res_valid, res_last, mm_start, mm_x_valid, mm_y_valid,
           res_data, mm_x, mm_y, mm_type} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got g=%b b=%b rv=%b rl=%b st=%b want all 0",
                  gnt, busy, res_valid, res_last, mm_start);
      end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({gnt, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL idle_after_reset got g=%b b=%b want 00 0", gnt, busy);
      end
   endtask

   task automatic test_single();
      logic [1:0] g, ty; logic st; bit tout;
      req_type = 4'b1110;       // requester 0: type 2, requester 1: type 3
      req = 2'b01;
      wait_gnt(g, st, ty, tout);
      vectors++;
      if (tout || {g, st, ty, busy} !== {2'b01, 1'b1, 2'd2, 1'b1}) begin
         miscompares++;
         $display("FAIL single_grant got g=%b st=%b ty=%0d b=%b want g=01 st=1 ty=2 b=1",
                  g, st, ty, busy);
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if ({gnt, mm_start, busy} !== 4'b0001) begin
         miscompares++;
         $display("FAIL grant_pulse got g=%b st=%b b=%b want 00 0 1", gnt, mm_start, busy);
      end
      fwd_cnt = 0;
      feed(0, N, 1'b0, 1'b0, 1'b0);
      drain(0, N);
      repeat (3) @(negedge clk);
      vectors++;
      if (fwd_cnt != N || exp_xy.size() != 0 || exp_res.size() != 0) begin
         miscompares++;
         $display("FAIL single_done got fwd=%0d xy=%0d res=%0d want %0d 0 0",
                  fwd_cnt, exp_xy.size(), exp_res.size(), N);
      end
   endtask

   task automatic test_contention();
      logic [1:0] g, ty; logic st; bit tout;
      logic [1:0] want [3];
      want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
      apply_reset();
      req = 2'b11;
      for (int j = 0; j < 3; j++) begin
         wait_gnt(g, st, ty, tout);
         vectors++;
         if (tout || g !== want[j]) begin
            miscompares++;
            $display("FAIL rr_grant%0d got %b want %b", j, g, want[j]);
         end
         if (j > 0) begin
            vectors++;
            if (gnt_cyc - last_cyc != 1) begin
               miscompares++;
               $display("FAIL busy_gap%0d got %0d want 1", j, gnt_cyc - last_cyc);
            end
         end
         if (j == 2) req = '0;
         feed((want[j] == 2'b10) ? 1 : 0, N, 1'b0, 1'b0, 1'b0);
         drain((want[j] == 2'b10) ? 1 : 0, N);
      end
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_xy.size() != 0 || exp_res.size() != 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rr_done got xy=%0d res=%0d b=%b want 0 0 0",
                  exp_xy.size(), exp_res.size(), busy);
      end
   endtask

   task automatic test_gapped();
      logic [1:0] g, ty; logic st; bit tout;
      req = 2'b01;
      wait_gnt(g, st, ty, tout);
      vectors++;
      if (tout || g !== 2'b01) begin
         miscompares++;
         $display("FAIL gap_grant got %b want 01", g);
      end
      req = '0;
      fwd_cnt = 0;
      feed(0, N, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      vectors++;
      if (fwd_cnt != N || exp_xy.size() != 0) begin
         miscompares++;
         $display("FAIL gap_count got %0d left=%0d want %0d 0", fwd_cnt, exp_xy.size(), N);
      end
      drain(0, N);
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_res.size() != 0) begin
         miscompares++;
         $display("FAIL gap_results got %0d left want 0", exp_res.size());
      end
   endtask

   task automatic test_overfeed();
      logic [1:0] g, ty; logic st; bit tout;
      req = 2'b10;
      req_type = 4'b0100;       // requester 1: type 1
      wait_gnt(g, st, ty, tout);
      vectors++;
      if (tout || g !== 2'b10 || ty !== 2'd1) begin
         miscompares++;
         $display("FAIL over_grant got g=%b ty=%0d want 10 1", g, ty);
      end
      req = '0;
      fwd_cnt = 0;
      feed(1, 40, 1'b0, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      vectors++;
      if (fwd_cnt != N || busy !== 1'b1 || res_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL over_count got fwd=%0d b=%b rv=%b want %0d 1 00",
                  fwd_cnt, busy, res_valid, N);
      end
      drain(1, N);
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_res.size() != 0 || exp_xy.size() != 0) begin
         miscompares++;
         $display("FAIL over_results got res=%0d xy=%0d want 0 0", exp_res.size(), exp_xy.size());
      end
   endtask

   task automatic test_abort();
      logic [1:0] g, ty; logic st; bit tout;
      req = 2'b01;
      wait_gnt(g, st, ty, tout);
      vectors++;
      if (tout || g !== 2'b01) begin
         miscompares++;
         $display("FAIL abort_grant got %b want 01", g);
      end
      req = '0;
      feed(0, N, 1'b0, 1'b0, 1'b0);
      drain(0, 11);             // beats 0..10 delivered, DUT still in DRAIN
      #2;
      rst_n = 1'b1;
      #1;
      vectors++;
      if ({gnt, busy, res_valid, res_last, mm_start, mm_x_valid, mm_y_valid,
           res_data, mm_x, mm_y, mm_type} !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs got b=%b rv=%b rl=%b data=%h want all 0",
                  busy, res_valid, res_last, res_data);
      end
      exp_xy.delete(); exp_res.delete();
      mm_valid = 1'b1;
      repeat (3) @(negedge clk);
      mm_valid = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, res_valid, res_last} !== 4'b0) begin
         miscompares++;
         $display("FAIL abort_quiet got b=%b rv=%b rl=%b want 0", busy, res_valid, res_last);
      end
      req = 2'b11;
      req_type = 4'b1110;
      wait_gnt(g, st, ty, tout);
      vectors++;
      if (tout || g !== 2'b01 || ty !== 2'd2) begin
         miscompares++;
         $display("FAIL post_abort_grant got g=%b ty=%0d want 01 2", g, ty);
      end
      req = '0;                 // requester 1 withdraws before being granted
      fwd_cnt = 0;
      feed(0, N, 1'b0, 1'b0, 1'b0);
      drain(0, N);
      repeat (5) @(negedge clk);
      vectors++;
      if (fwd_cnt != N || exp_res.size() != 0 || busy !== 1'b0 || gnt !== 2'b00) begin
         miscompares++;
         $display("FAIL post_abort_done got fwd=%0d res=%0d b=%b g=%b want %0d 0 0 00",
                  fwd_cnt, exp_res.size(), busy, gnt, N);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_gapped();
      test_overfeed();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mm_req_arb.md
MM_REQ_ARB -- requirements
Module: mm_req_arb

Interface
REQ-001 Parameter K, default 128, word width in bits of every operand and result beat.
REQ-002 Parameter N, default 32, number of words per operand and per result.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  per-requester request; held high until granted.
REQ-006 req_type  input  4  2-bit modulus select per requester; requester i uses bits [2i+1:2i].
REQ-007 req_x  input  2*K  operand-x word per requester; requester i uses bits [iK+K-1:iK].
REQ-008 req_y  input  2*K  operand-y word per requester; same slicing as req_x.
REQ-009 req_valid  input  2  per-requester operand-beat valid.
REQ-010 gnt  output  2  one-hot, single-cycle grant pulse.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 res_data  output  K  result word broadcast to both requesters.
REQ-013 res_valid  output  2  result-beat valid, asserted only to the owning requester.
REQ-014 res_last  output  1  high with the final (Nth) result beat.
REQ-015 mm_type, mm_start, mm_x, mm_x_valid, mm_y, mm_y_valid  outputs  2/1/K/1/K/1  drive the shared Montgomery core.
REQ-016 mm_result  input  K; mm_valid  input  1  result stream from the core.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT, DRAIN; it SHALL leave IDLE only when any req bit is high.
REQ-018 In IDLE with a nonzero req, the next cycle SHALL assert gnt[w] for exactly one cycle, assert mm_start for that same cycle, load mm_type from the winner's req_type, set owner=w, and enter LOAD.
REQ-019 Arbitration SHALL be round-robin: the requester granted last has lowest priority. After reset, requester 0 has highest priority.
REQ-020 In LOAD, each cycle with req_valid[owner]=1 SHALL register req_x/req_y of the owner onto mm_x/mm_y one cycle later, with mm_x_valid=mm_y_valid=1, and increment a beat counter.
REQ-021 req_valid of the non-owner SHALL be ignored in every state.
REQ-022 After the Nth accepted beat, the FSM SHALL enter WAIT. Valid beats beyond N SHALL be ignored. mm_x_valid and mm_y_valid SHALL be 0 in every cycle that has no forwarded beat.
REQ-023 In WAIT, the first cycle with mm_valid=1 SHALL enter DRAIN, and that cycle's mm_result SHALL be result beat 0.
REQ-024 Result beats SHALL be taken on N consecutive cycles starting at beat 0, regardless of mm_valid after beat 0. Each beat SHALL appear registered one cycle later on res_data, with res_valid[owner]=1.
REQ-025 res_last SHALL accompany beat N-1. The FSM SHALL return to IDLE in that same cycle. Back-to-back grants SHALL be possible, with the next gnt no earlier than the cycle after res_last.
REQ-026 A req that deasserts before its grant SHALL be dropped without side effects. Requests arriving outside IDLE SHALL wait.
REQ-027 Beat counters SHALL be ceil(log2(N+1)) bits wide and SHALL clear on every IDLE entry.
REQ-028 mm_valid seen in IDLE or LOAD SHALL be ignored.

Reset
REQ-029 While rst_n is high, the FSM SHALL be IDLE, owner SHALL be 0, the round-robin pointer SHALL give requester 0 priority, and the counters SHALL be 0.
REQ-030 While rst_n is high, gnt, busy, res_valid, res_last, mm_start, mm_x_valid and mm_y_valid SHALL be 0, and res_data, mm_x, mm_y and mm_type SHALL be 0.
REQ-031 Reset asserted mid-LOAD or mid-DRAIN SHALL abort immediately. No further res_valid SHALL be produced for the aborted job.

Verification
REQ-032 Single job: req=01, type 2, N beats of x and y (the same operands as the existing core bench) -> gnt=01 with mm_start in the same cycle, mm_type=2, then N forwarded beats and N res_valid[0] beats matching the reference product, with res_last on beat N-1.
REQ-033 Contention: req=11 held out of reset -> grants in order 01, 10, 01. res_valid only ever goes to the current owner. busy stays low for at most 1 cycle between jobs.
REQ-034 Gapped input: owner drives 32 beats with req_valid toggling every other cycle, and the non-owner drives req_valid=1 throughout -> exactly 32 mm_x_valid pulses, all carrying the owner's data.
REQ-035 Over-feed and early mm_valid: 40 beats driven, plus an mm_valid pulse during LOAD -> only 32 beats forwarded, the spurious mm_valid is ignored, and DRAIN starts on the first mm_valid in WAIT.
REQ-036 Reset mid-DRAIN after beat 10 -> all outputs are 0 within the reset cycle. The next job after release starts with a grant to requester 0 and completes correctly.
